// File: rtl/nmr_pulse_sequencer.sv
// -----------------------------------------------------------------------------
// nmr_pulse_sequencer
// Table-driven pulse programmer for the DDS signal generator. A table of up to
// DEPTH segments (duration, frequency word, TX select, RF gate, acquire gate,
// last flag) is written while idle. A start plays the segments back-to-back
// from entry 0 up to the first entry flagged last (or the final entry), and
// repeats that pass n_repeats extra times.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   cfg_we/cfg_addr/cfg_*    table write port (accepted only while idle)
//   n_repeats                extra passes, captured on an accepted start
//   start, abort             single-cycle control requests
//   busy, done, aborted      run status (done/aborted are 1-cycle pulses)
//   seg_idx, pass_cnt        current segment and completed passes
//   sg_enable/sg_frq/sg_tx   signal generator controls
//   acq_gate                 receiver acquisition window
// -----------------------------------------------------------------------------
module nmr_pulse_sequencer #(
    parameter int DEPTH = 16,
    parameter int LEN_W = 32,
    parameter int FRQ_W = 32,
    parameter int REP_W = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [FRQ_W-1:0] cfg_frq,
    input  logic [1:0]       cfg_tx,
    input  logic             cfg_gate,
    input  logic             cfg_acq,
    input  logic             cfg_last,
    input  logic [REP_W-1:0] n_repeats,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [AW-1:0]    seg_idx,
    output logic [REP_W-1:0] pass_cnt,
    output logic             sg_enable,
    output logic [FRQ_W-1:0] sg_frq,
    output logic [1:0]       sg_tx,
    output logic             acq_gate
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    // Segment table
    logic [LEN_W-1:0] tbl_len  [DEPTH];
    logic [FRQ_W-1:0] tbl_frq  [DEPTH];
    logic [1:0]       tbl_tx   [DEPTH];
    logic             tbl_gate [DEPTH];
    logic             tbl_acq  [DEPTH];
    logic             tbl_last [DEPTH];

    state_t           state_reg,    state_next;
    logic [AW-1:0]    seg_idx_reg,  seg_idx_next;
    logic [REP_W-1:0] pass_reg,     pass_next;
    logic [REP_W-1:0] target_reg,   target_next;
    logic [LEN_W-1:0] count_reg,    count_next;
    logic             busy_reg,     busy_next;
    logic             done_reg,     done_next;
    logic             aborted_reg,  aborted_next;
    logic             en_reg,       en_next;
    logic             acq_reg,      acq_next;
    logic [FRQ_W-1:0] frq_reg,      frq_next;
    logic [1:0]       tx_reg,       tx_next;

    logic             tbl_wr_en;
    logic             load_en;
    logic [AW-1:0]    load_idx;
    logic             pass_end;

    // Writes while a run is in progress are dropped so a playing sequence
    // never sees its own table change underneath it.
    assign tbl_wr_en = cfg_we && (state_reg == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_len[i]  <= '0;
                tbl_frq[i]  <= '0;
                tbl_tx[i]   <= '0;
                tbl_gate[i] <= 1'b0;
                tbl_acq[i]  <= 1'b0;
                tbl_last[i] <= 1'b0;
            end
        end else if (tbl_wr_en) begin
            tbl_len[cfg_addr]  <= cfg_len;
            tbl_frq[cfg_addr]  <= cfg_frq;
            tbl_tx[cfg_addr]   <= cfg_tx;
            tbl_gate[cfg_addr] <= cfg_gate;
            tbl_acq[cfg_addr]  <= cfg_acq;
            tbl_last[cfg_addr] <= cfg_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            seg_idx_reg <= '0;
            pass_reg    <= '0;
            target_reg  <= '0;
            count_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
            en_reg      <= 1'b0;
            acq_reg     <= 1'b0;
            frq_reg     <= '0;
            tx_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            seg_idx_reg <= seg_idx_next;
            pass_reg    <= pass_next;
            target_reg  <= target_next;
            count_reg   <= count_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            aborted_reg <= aborted_next;
            en_reg      <= en_next;
            acq_reg     <= acq_next;
            frq_reg     <= frq_next;
            tx_reg      <= tx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        seg_idx_next = seg_idx_reg;
        pass_next    = pass_reg;
        target_next  = target_reg;
        count_next   = count_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        aborted_next = 1'b0;
        en_next      = en_reg;
        acq_next     = acq_reg;
        frq_next     = frq_reg;
        tx_next      = tx_reg;
        load_en      = 1'b0;
        load_idx     = '0;
        // The final table entry always ends a pass so seg_idx never wraps.
        pass_end     = tbl_last[seg_idx_reg] || (seg_idx_reg == AW'(DEPTH - 1));

        case (state_reg)
            ST_IDLE: begin
                en_next   = 1'b0;
                acq_next  = 1'b0;
                busy_next = 1'b0;
                if (start && !abort) begin
                    state_next  = ST_RUN;
                    busy_next   = 1'b1;
                    pass_next   = '0;
                    target_next = n_repeats;
                    load_en     = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next   = ST_IDLE;
                    aborted_next = 1'b1;
                    busy_next    = 1'b0;
                    en_next      = 1'b0;
                    acq_next     = 1'b0;
                end else if (count_reg != '0) begin
                    count_next = count_reg - 1'b1;
                end else if (pass_end) begin
                    if (pass_reg < target_reg) begin
                        pass_next = pass_reg + 1'b1;
                        load_en   = 1'b1;
                    end else begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                        en_next    = 1'b0;
                        acq_next   = 1'b0;
                    end
                end else begin
                    load_en  = 1'b1;
                    load_idx = seg_idx_reg + 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
                en_next    = 1'b0;
                acq_next   = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Segment load: the countdown holds max(len,1)-1 so that a segment
        // occupies exactly max(len,1) cycles and the next one follows at once.
        if (load_en) begin
            seg_idx_next = load_idx;
            count_next   = (tbl_len[load_idx] == '0) ? '0 : tbl_len[load_idx] - 1'b1;
            en_next      = tbl_gate[load_idx];
            acq_next     = tbl_acq[load_idx];
            frq_next     = tbl_frq[load_idx];
            tx_next      = tbl_tx[load_idx];
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign aborted   = aborted_reg;
    assign seg_idx   = seg_idx_reg;
    assign pass_cnt  = pass_reg;
    assign sg_enable = en_reg;
    assign sg_frq    = frq_reg;
    assign sg_tx     = tx_reg;
    assign acq_gate  = acq_reg;

endmodule

// File: tb/tb_nmr_pulse_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nmr_pulse_sequencer
// Directed and randomized checks of nmr_pulse_sequencer. The expected per-cycle
// output trace of each run is built from the segment table model as a flat
// list of cycles (each segment expanded to max(len,1) entries, per pass),
// followed by the done or aborted cycle and one idle cycle.
// -----------------------------------------------------------------------------
module tb_nmr_pulse_sequencer;
    localparam int DEPTH = 16;
    localparam int LEN_W = 32;
    localparam int FRQ_W = 32;
    localparam int REP_W = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [AW-1:0]    cfg_addr = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic [FRQ_W-1:0] cfg_frq = '0;
    logic [1:0]       cfg_tx = '0;
    logic             cfg_gate = 1'b0;
    logic             cfg_acq = 1'b0;
    logic             cfg_last = 1'b0;
    logic [REP_W-1:0] n_repeats = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             busy, done, aborted, sg_enable, acq_gate;
    logic [AW-1:0]    seg_idx;
    logic [REP_W-1:0] pass_cnt;
    logic [FRQ_W-1:0] sg_frq;
    logic [1:0]       sg_tx;

    nmr_pulse_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W), .FRQ_W(FRQ_W), .REP_W(REP_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_len(cfg_len), .cfg_frq(cfg_frq), .cfg_tx(cfg_tx), .cfg_gate(cfg_gate),
        .cfg_acq(cfg_acq), .cfg_last(cfg_last), .n_repeats(n_repeats),
        .start(start), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
        .seg_idx(seg_idx), .pass_cnt(pass_cnt), .sg_enable(sg_enable),
        .sg_frq(sg_frq), .sg_tx(sg_tx), .acq_gate(acq_gate)
    );

    always #5 clk = ~clk;

    // Table model
    int unsigned m_len  [DEPTH];
    logic [31:0] m_frq  [DEPTH];
    logic [1:0]  m_tx   [DEPTH];
    bit          m_gate [DEPTH];
    bit          m_acq  [DEPTH];
    bit          m_last [DEPTH];
    logic [63:0] idle_exp;

    int n_checks = 0;
    int n_pass   = 0;

    // Packed view: busy,done,aborted,sg_enable,acq_gate,sg_tx,seg_idx,pass_cnt,sg_frq
    function automatic logic [63:0] pk(bit b, bit d, bit a, bit en, bit acq,
                                       logic [1:0] tx, logic [3:0] idx,
                                       logic [15:0] pc, logic [31:0] frq);
        return {5'b0, b, d, a, en, acq, tx, idx, pc, frq};
    endfunction

    function automatic logic [63:0] obs();
        return pk(busy, done, aborted, sg_enable, acq_gate, sg_tx, seg_idx, pass_cnt, sg_frq);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            m_len[i] = 0; m_frq[i] = '0; m_tx[i] = '0;
            m_gate[i] = 0; m_acq[i] = 0; m_last[i] = 0;
        end
        idle_exp = '0;
    endtask

    task automatic write_seg(input int idx, input int unsigned len, input logic [31:0] frq,
                             input logic [1:0] tx, input bit gate, input bit acq, input bit last);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 4'(idx); cfg_len = len; cfg_frq = frq;
        cfg_tx = tx; cfg_gate = gate; cfg_acq = acq; cfg_last = last;
        m_len[idx] = len; m_frq[idx] = frq; m_tx[idx] = tx;
        m_gate[idx] = gate; m_acq[idx] = acq; m_last[idx] = last;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    function automatic int run_len(input int nrep);
        int sum = 0;
        for (int s = 0; s < DEPTH; s++) begin
            sum += (m_len[s] == 0) ? 1 : int'(m_len[s]);
            if (m_last[s]) break;
        end
        return (nrep + 1) * sum;
    endfunction

    // abort_at/start_at/wr_at: 1-based cycle after whose check the request is
    // driven (taken on the following edge); 0 disables it.
    task automatic run_seq(input int nrep, input int abort_at, input int start_at,
                           input int wr_at, input string tag);
        logic [63:0] q[$];
        logic [63:0] e;
        int s;
        int rl;
        for (int p = 0; p <= nrep; p++) begin
            s = 0;
            while (1) begin
                for (int k = 0; k < ((m_len[s] == 0) ? 1 : int'(m_len[s])); k++)
                    q.push_back(pk(1, 0, 0, m_gate[s], m_acq[s], m_tx[s], 4'(s), 16'(p), m_frq[s]));
                if (m_last[s] || s == DEPTH - 1) break;
                s++;
            end
        end
        rl = q.size();
        if (abort_at >= 1 && abort_at <= rl) begin
            while (q.size() > abort_at) void'(q.pop_back());
            e = q[$];
            e[58] = 1'b0; e[56] = 1'b1; e[55] = 1'b0; e[54] = 1'b0;
        end else begin
            e = q[$];
            e[58] = 1'b0; e[57] = 1'b1; e[55] = 1'b0; e[54] = 1'b0;
        end
        q.push_back(e);
        e[57] = 1'b0; e[56] = 1'b0;
        q.push_back(e);
        idle_exp = e;

        @(negedge clk);
        n_repeats = 16'(nrep);
        start = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
            check($sformatf("%s c%0d", tag, i + 1), obs(), q[i]);
            if (i + 1 == abort_at) abort = 1'b1;
            if (i + 1 == start_at) start = 1'b1;
            if (i + 1 == wr_at) begin
                cfg_we = 1'b1; cfg_addr = 4'($urandom_range(0, DEPTH - 1));
                cfg_len = $urandom_range(1, 9); cfg_frq = $urandom;
                cfg_tx = 2'($urandom); cfg_gate = 1'b1; cfg_acq = 1'b1; cfg_last = 1'b1;
            end
        end
        $display("run %s nrep=%0d abort_at=%0d cycles=%0d", tag, nrep, abort_at, q.size());
    endtask

    task automatic prog_t2();
        clear_table();
        write_seg(0, 4, 32'd400000000, 2'd0, 1, 0, 0);
        write_seg(1, 10, 32'd12345678, 2'd1, 0, 1, 1);
    endtask

    task automatic clear_table();
        for (int i = 0; i < DEPTH; i++) write_seg(i, 0, '0, '0, 0, 0, 0);
    endtask

    initial begin
        int rl, ab, lim, st, wr;
        clear_model();
        repeat (3) @(negedge clk);
        check("reset_out", obs(), '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", obs(), '0);

        // Basic two-segment program
        prog_t2();
        run_seq(0, 0, 0, 0, "t2");

        // Reset mid-run: outputs clear without waiting for a clock edge
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1 check("reset_midrun", obs(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        @(negedge clk);
        check("idle_after_midrun_reset", obs(), '0);

        // Repeats and abort
        prog_t2();
        run_seq(2, 0, 0, 0, "t3");
        run_seq(0, 3, 0, 0, "t5");
        run_seq(0, 0, 0, 0, "t5_replay");

        // Zero length treated as one cycle
        write_seg(0, 0, 32'hDEADBEEF, 2'd3, 1, 0, 1);
        run_seq(0, 0, 0, 0, "t4");

        // No last flag: full table, with a dropped mid-run write
        for (int i = 0; i < DEPTH; i++) write_seg(i, 1, 32'(1000 + i), 2'(i), i[0], i[1], 0);
        run_seq(0, 0, 0, 5, "t6");
        run_seq(0, 0, 0, 0, "t6_again");

        // Abort wins over start in IDLE
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("idle_abort_start", obs(), idle_exp);
        @(negedge clk);
        check("idle_abort_start2", obs(), idle_exp);

        // Randomized programs
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < DEPTH; i++)
                write_seg(i, $urandom_range(0, 4), $urandom, 2'($urandom), 1'($urandom),
                          1'($urandom), ($urandom_range(0, 3) == 0));
            rl  = run_len(it % 3);
            ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, rl + 1) : 0;
            lim = (ab >= 1 && ab <= rl) ? ab : rl + 1;
            st  = $urandom_range(1, lim);
            wr  = $urandom_range(1, (lim > rl) ? rl : lim);
            run_seq(it % 3, ab, st, wr, $sformatf("rnd%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
